// File: rtl/game_seq_ctrl.sv
// Run/pause/level-select/game-over sequencer with a level-scaled game tick divider.
// Every output is registered; command pulses are one cycle and follow the triggering input by one clock.
module game_seq_ctrl #(
  parameter int TICK_BASE      = 5000000,
  parameter int TICK_STEP      = 500000,
  parameter int MAX_LEVEL      = 7,
  parameter int PASS_PER_LEVEL = 10,
  parameter int DIV_W          = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       adj,
  input  logic [2:0] num,
  input  logic       obstacle_passed,
  input  logic       collision,
  output logic [2:0] state,
  output logic       running,
  output logic       game_tick,
  output logic       score_clr,
  output logic       score_inc,
  output logic       level_load,
  output logic       level_inc,
  output logic [2:0] level_val,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LVL_SEL = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSED  = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  localparam int          PW        = (PASS_PER_LEVEL > 1) ? $clog2(PASS_PER_LEVEL) : 1;
  localparam logic [2:0]  LV_MAX    = 3'(MAX_LEVEL);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASS_PER_LEVEL - 1);
  localparam logic [31:0] BASE_M1   = 32'(TICK_BASE - 1);
  localparam logic [31:0] STEP      = 32'(TICK_STEP);

  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [PW-1:0]    r_pass;
  logic [2:0]       r_level;
  logic             r_running, r_tick, r_clr, r_inc, r_load, r_linc, r_over;

  state_t           w_nxt_state;
  logic [DIV_W-1:0] w_nxt_div;
  logic [PW-1:0]    w_nxt_pass;
  logic [2:0]       w_nxt_level;
  logic             w_tick, w_clr, w_inc, w_load, w_linc, w_adv;
  logic [31:0]      w_prd_m1;
  logic             w_wrap;
  logic [2:0]       w_sel;

  // >= rather than == so a level-up that shortens the period below the count still wraps at once.
  assign w_prd_m1 = BASE_M1 - ({29'd0, r_level} * STEP);
  assign w_wrap   = (32'(r_div) >= w_prd_m1);
  assign w_sel    = (num > LV_MAX) ? LV_MAX : num;

  always_comb begin
    w_nxt_state = state_t'(r_state);
    w_nxt_div   = r_div;
    w_nxt_pass  = r_pass;
    w_nxt_level = r_level;
    w_tick      = 1'b0;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_load      = 1'b0;
    w_linc      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (adj) begin
          w_nxt_state = S_LVL_SEL;
        end else if (btn_start) begin
          w_nxt_state = S_RUN;
          w_clr       = 1'b1;
          w_load      = 1'b1;
          w_nxt_div   = '0;
          w_nxt_pass  = '0;
        end
      end
      S_LVL_SEL: begin
        w_nxt_level = w_sel;
        if (!adj) w_nxt_state = S_IDLE;
      end
      S_RUN: begin
        if (collision) begin
          w_nxt_state = S_OVER;
        end else begin
          if (btn_pause) w_nxt_state = S_PAUSED;
          else           w_adv       = 1'b1;
          if (obstacle_passed) begin
            w_inc = 1'b1;
            if (r_pass == PASS_LAST) begin
              w_nxt_pass = '0;
              if (r_level < LV_MAX) begin
                w_nxt_level = r_level + 3'd1;
                w_linc      = 1'b1;
              end
            end else begin
              w_nxt_pass = r_pass + PW'(1);
            end
          end
        end
      end
      S_PAUSED: begin
        // The resuming edge counts, so the count picks up exactly where the pause froze it.
        if (btn_pause) begin
          w_nxt_state = S_RUN;
          w_adv       = 1'b1;
        end
      end
      S_OVER: begin
        if (btn_start) w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
    if (w_adv) begin
      if (w_wrap) begin
        w_nxt_div = '0;
        w_tick    = 1'b1;
      end else begin
        w_nxt_div = r_div + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_pass    <= '0;
      r_level   <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_clr     <= 1'b0;
      r_inc     <= 1'b0;
      r_load    <= 1'b0;
      r_linc    <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_div     <= w_nxt_div;
      r_pass    <= w_nxt_pass;
      r_level   <= w_nxt_level;
      r_running <= (w_nxt_state == S_RUN);
      r_tick    <= w_tick;
      r_clr     <= w_clr;
      r_inc     <= w_inc;
      r_load    <= w_load;
      r_linc    <= w_linc;
      r_over    <= (w_nxt_state == S_OVER);
    end
  end

  assign state      = r_state;
  assign running    = r_running;
  assign game_tick  = r_tick;
  assign score_clr  = r_clr;
  assign score_inc  = r_inc;
  assign level_load = r_load;
  assign level_inc  = r_linc;
  assign level_val  = r_level;
  assign game_over  = r_over;

endmodule
